mul_div_unit: RTL and testbench



---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mdu_div_step.sv | 23 ++
 rtl/mul_div_unit.sv | 179 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int OP_MULT  = 3;
  localparam int OP_MULTU = 2;
  localparam int OP_DIV   = 1;
  localparam int OP_DIVU  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  typedef enum logic [1:0] {
    K_NONE = 2'd0,
    K_MUL  = 2'd1,
    K_DIV  = 2'd2
  } mdu_kind_e;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shf;
  logic [WIDTH:0] diff;

  // rem_i < dsr_i, so a clear borrow bit means the trial fits.
  always_comb begin
    shf   = {rem_i, bit_i};
    diff  = shf - {1'b0, dsr_i};
    q_o   = ~diff[WIDTH];
    rem_o = q_o ? diff[WIDTH-1:0] : shf[WIDTH-1:0];
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 mult/multu/div/divu unit with valid/ready handshakes.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo,
  output logic             busy
);

  localparam int W2 = 2 * WIDTH;

  mdu_state_e       state_q, state_d;
  mdu_kind_e        kind_q, kind_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             dz_q, dz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] src1_q, src1_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  mdu_kind_e        dec_kind;
  logic             dec_sgn;
  logic             sa, sb;
  logic [WIDTH-1:0] abs1, abs2;
  logic [WIDTH:0]   sum;
  logic [W2-1:0]    mul_next, div_next, prod;
  logic [WIDTH-1:0] rem_new;
  logic             q_bit;

  mdu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (acc_q[W2-1:WIDTH]),
    .bit_i (acc_q[WIDTH-1]),
    .dsr_i (opnd_q),
    .rem_o (rem_new),
    .q_o   (q_bit)
  );

  always_comb begin
    dec_kind = K_NONE;
    dec_sgn  = 1'b0;
    priority case (1'b1)
      op[OP_MULT]:  begin dec_kind = K_MUL; dec_sgn = 1'b1; end
      op[OP_MULTU]: dec_kind = K_MUL;
      op[OP_DIV]:   begin dec_kind = K_DIV; dec_sgn = 1'b1; end
      op[OP_DIVU]:  dec_kind = K_DIV;
      default:      dec_kind = K_NONE;
    endcase
    sa   = dec_sgn & src1[WIDTH-1];
    sb   = dec_sgn & src2[WIDTH-1];
    abs1 = sa ? -src1 : src1;
    abs2 = sb ? -src2 : src2;
  end

  // Shift-add: multiplier sits in the low half and drains out the bottom.
  always_comb begin
    sum = {1'b0, acc_q[W2-1:WIDTH]}
        + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {sum, acc_q[WIDTH-1:1]};
    div_next = {rem_new, acc_q[WIDTH-2:0], q_bit};
    prod     = (s1_q ^ s2_q) ? -acc_q : acc_q;
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    dz_d    = dz_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    src1_d  = src1_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          state_d = CALC;
          kind_d  = dec_kind;
          s1_d    = sa;
          s2_d    = sb;
          dz_d    = (src2 == '0);
          cnt_d   = '0;
          src1_d  = src1;
          if (dec_kind == K_DIV) begin
            acc_d  = {{WIDTH{1'b0}}, abs1};
            opnd_d = abs2;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, abs2};
            opnd_d = abs1;
          end
        end
        CALC: begin
          acc_d = (kind_q == K_DIV) ? div_next : mul_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
        end
        FIX: begin
          state_d = DONE;
          unique case (kind_q)
            K_MUL: begin
              hi_d = prod[W2-1:WIDTH];
              lo_d = prod[WIDTH-1:0];
            end
            K_DIV: begin
              if (dz_q) begin
                hi_d = src1_q;
                lo_d = '1;
              end else begin
                hi_d = s1_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
                lo_d = (s1_q ^ s2_q) ? -acc_q[WIDTH-1:0]
                                     : acc_q[WIDTH-1:0];
              end
            end
            default: begin
              hi_d = '0;
              lo_d = '0;
            end
          endcase
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      kind_q  <= K_NONE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      src1_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      dz_q    <= dz_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      src1_q  <= src1_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_hi    = hi_q;
  assign out_lo    = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed vectors, decoupled monitor.
module tb_mul_div_unit;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  localparam logic [3:0] MULT  = 4'b1000;
  localparam logic [3:0] MULTU = 4'b0100;
  localparam logic [3:0] DIV   = 4'b0010;
  localparam logic [3:0] DIVU  = 4'b0001;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready;
  logic         out_valid, out_ready, busy;
  logic [3:0]   op;
  logic [W-1:0] src1, src2, out_hi, out_lo;

  typedef struct {
    string        tag;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
  } exp_t;

  exp_t         sbq[$];
  string        exp_tag;
  logic [W-1:0] exp_hi, exp_lo;
  int           cyc = 0;
  int           acc_cnt = 0;
  int           checks = 0;
  int           errors = 0;
  bit           seen = 1'b0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hi    (out_hi),
    .out_lo    (out_lo),
    .busy      (busy)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst || flush) sbq.delete();
    else if (in_valid && in_ready) begin
      sbq.push_back('{exp_tag, exp_hi, exp_lo, cyc});
      acc_cnt++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!out_valid) seen = 1'b0;
    else if (!seen) begin
      seen = 1'b1;
      if (sbq.size() == 0) begin
        chk("no_spurious_valid", 64'(out_valid), 64'd0);
      end else begin
        e = sbq.pop_front();
        chk({e.tag, "_hi"}, 64'(out_hi), 64'(e.hi));
        chk({e.tag, "_lo"}, 64'(out_lo), 64'(e.lo));
        chk({e.tag, "_latency"}, 64'(cyc - e.cyc + 1), 64'(LAT));
      end
    end
  end

  task automatic issue(string tag, logic [3:0] o, logic [W-1:0] a,
                       logic [W-1:0] b, logic [W-1:0] eh,
                       logic [W-1:0] el);
    int start;
    int n;
    @(negedge clk);
    exp_tag  = tag;
    exp_hi   = eh;
    exp_lo   = el;
    op       = o;
    src1     = a;
    src2     = b;
    in_valid = 1'b1;
    start    = acc_cnt;
    n        = 0;
    while (acc_cnt == start && n < 500) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk({tag, "_accepted"}, 64'(acc_cnt - start), 64'd1);
  endtask

  task automatic wait_valid(string tag);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid_seen"}, 64'(out_valid), 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((!in_ready || sbq.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] h, l;
    bit low_ok;
    int n;
    int start;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; src1 = '0; src2 = '0;
    exp_tag = ""; exp_hi = '0; exp_lo = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_hi", 64'(out_hi), 64'd0);
    chk("rst_out_lo", 64'(out_lo), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    issue("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
          32'hFFFFFFFE, 32'h00000001);
    low_ok = 1'b1;
    n = 0;
    while (!out_valid && n < 200) begin
      if (in_ready) low_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("in_ready_low_while_busy", 64'(low_ok), 64'd1);
    chk("in_ready_low_in_done", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("in_ready_after_hs", 64'(in_ready), 64'd1);
    chk("valid_drop_after_hs", 64'(out_valid), 64'd0);

    issue("mult_neg3x5", MULT, 32'hFFFFFFFD, 32'd5,
          32'hFFFFFFFF, 32'hFFFFFFF1);
    issue("mult_minxmin", MULT, 32'h80000000, 32'h80000000,
          32'h40000000, 32'h00000000);
    issue("div_neg7_2", DIV, 32'hFFFFFFF9, 32'd2,
          32'hFFFFFFFF, 32'hFFFFFFFD);
    issue("divu_neg7_2", DIVU, 32'hFFFFFFF9, 32'd2,
          32'h00000001, 32'h7FFFFFFC);
    issue("div_min_m1", DIV, 32'h80000000, 32'hFFFFFFFF,
          32'h00000000, 32'h80000000);
    issue("divu_7_0", DIVU, 32'd7, 32'd0,
          32'h00000007, 32'hFFFFFFFF);
    issue("div_neg7_0", DIV, 32'hFFFFFFF9, 32'd0,
          32'hFFFFFFF9, 32'hFFFFFFFF);
    issue("div_100_7", DIV, 32'd100, 32'd7,
          32'd2, 32'd14);
    issue("op_none", 4'b0000, 32'd5, 32'd7, 32'd0, 32'd0);
    issue("prio_all", 4'b1111, 32'hFFFFFFFD, 32'd5,
          32'hFFFFFFFF, 32'hFFFFFFF1);
    issue("prio_div", 4'b0011, 32'hFFFFFFF9, 32'd2,
          32'hFFFFFFFF, 32'hFFFFFFFD);
    wait_idle();

    issue("div_flushed", DIV, 32'd1000, 32'd3, 32'd1, 32'd333);
    repeat (9) @(negedge clk);
    start = acc_cnt;
    exp_tag = "flush_edge_req";
    op = MULT; src1 = 32'd2; src2 = 32'd2;
    flush = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_no_accept", 64'(acc_cnt - start), 64'd0);
    repeat (40) @(negedge clk);
    issue("multu_6x7", MULTU, 32'd6, 32'd7, 32'd0, 32'd42);
    wait_idle();

    out_ready = 1'b0;
    issue("mult_bp", MULT, 32'd3, 32'hFFFFFFFB,
          32'hFFFFFFFF, 32'hFFFFFFF1);
    wait_valid("mult_bp");
    h = out_hi;
    l = out_lo;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_held", 64'(out_valid), 64'd1);
      chk("bp_hi_stable", 64'(out_hi), 64'(h));
      chk("bp_lo_stable", 64'(out_lo), 64'(l));
      chk("bp_busy", 64'(busy), 64'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 64'(out_valid), 64'd0);
    wait_idle();

    issue("mult_reset", MULT, 32'd9, 32'd9, 32'd0, 32'd81);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_hi", 64'(out_hi), 64'd0);
    chk("midrst_out_lo", 64'(out_lo), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    repeat (50) @(negedge clk);
    chk("midrst_quiet", 64'(out_valid), 64'd0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
